// File: rtl/rs232_frame_deframer.sv
// Deframes sync/length header, payload words and sum trailer from an RS232 word stream into a packet stream.
// Define DEFRAMER_ACK_EN to add the ACK state and acknowledge-word handshake towards the transmitter.
module rs232_frame_deframer #(
    parameter logic [7:0]  SYNC_BYTE   = 8'h37,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic [15:0] rx_q_i,
    input  logic        rx_dv_i,
    output logic [15:0] tx_data_o,
    output logic        tx_dv_o,
    input  logic        tx_busy_i,
    output logic [15:0] pkt_data_o,
    output logic        pkt_valid_o,
    output logic        pkt_last_o,
    input  logic        pkt_ready_i,
    output logic        frame_ok_o,
    output logic        frame_err_o,
    output logic        drop_o
);
    localparam int unsigned NW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
        S_CHECK   = 3'd2,
        S_DRAIN   = 3'd3
`ifdef DEFRAMER_ACK_EN
        , S_ACK   = 3'd4
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [NW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [NW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]     sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     pkt_data_q, pkt_data_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            pkt_last_q, pkt_last_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic            drop_q, drop_d;
    logic            mem_we_c;
    logic            timeout_c;
    logic            sync_c;
    logic            len_ok_c;
    logic [15:0]     mem_q [DEPTH];
`ifdef DEFRAMER_ACK_EN
    logic            ok_q, ok_d;
    logic [15:0]     tx_data_q, tx_data_d;
    logic            tx_dv_q, tx_dv_d;
`endif

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wr_cnt_d    = wr_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        sum_d       = sum_q;
        cnt_d       = '0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        drop_d      = 1'b0;
        mem_we_c    = 1'b0;
`ifdef DEFRAMER_ACK_EN
        ok_d        = ok_q;
        tx_data_d   = '0;
        tx_dv_d     = 1'b0;
`endif
        timeout_c = ((state_q == S_PAYLOAD) || (state_q == S_CHECK)) &&
                    (cnt_q == CW'(TIMEOUT_CYC - 1));
        sync_c    = rx_dv_i && (rx_q_i[15:8] == SYNC_BYTE);
        len_ok_c  = (rx_q_i[3:0] != 4'd0) && (32'(rx_q_i[3:0]) <= DEPTH);

        if (timeout_c) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
        end

        // A word landing on the timeout cycle is handled as if the frame had already been dropped
        if ((state_q == S_IDLE) || timeout_c) begin
            if (sync_c) begin
                if (len_ok_c) begin
                    n_d      = NW'(rx_q_i[3:0]);
                    sum_d    = '0;
                    wr_cnt_d = '0;
                    rd_ptr_d = '0;
                    state_d  = S_PAYLOAD;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                S_PAYLOAD: begin
                    if (rx_dv_i) begin
                        mem_we_c = 1'b1;
                        sum_d    = sum_q + rx_q_i;
                        wr_cnt_d = wr_cnt_q + NW'(1);
                        if (wr_cnt_q == n_q - NW'(1)) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_CHECK: begin
                    if (rx_dv_i) begin
`ifdef DEFRAMER_ACK_EN
                        ok_d    = (rx_q_i == sum_q);
                        state_d = S_ACK;
`else
                        frame_ok_d  = (rx_q_i == sum_q);
                        frame_err_d = (rx_q_i != sum_q);
                        state_d     = (rx_q_i == sum_q) ? S_DRAIN : S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef DEFRAMER_ACK_EN
                S_ACK: begin
                    drop_d = rx_dv_i;
                    if (!tx_busy_i) begin
                        tx_dv_d     = 1'b1;
                        tx_data_d   = ok_q ? 16'hA5A5 : 16'h5A5A;
                        frame_ok_d  = ok_q;
                        frame_err_d = !ok_q;
                        state_d     = ok_q ? S_DRAIN : S_IDLE;
                    end
                end
`endif
                S_DRAIN: begin
                    drop_d = rx_dv_i;
                    if (pkt_valid_q && pkt_ready_i) begin
                        rd_ptr_d = rd_ptr_q + NW'(1);
                        if (pkt_last_q) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pkt_valid_d = (state_d == S_DRAIN);
        pkt_last_d  = pkt_valid_d && (rd_ptr_d == n_q - NW'(1));
        pkt_data_d  = pkt_valid_d ? mem_q[PW'(rd_ptr_d)] : 16'h0000;
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= 1'b0;
`ifdef DEFRAMER_ACK_EN
            ok_q        <= 1'b0;
            tx_data_q   <= '0;
            tx_dv_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_last_q  <= pkt_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            drop_q      <= drop_d;
`ifdef DEFRAMER_ACK_EN
            ok_q        <= ok_d;
            tx_data_q   <= tx_data_d;
            tx_dv_q     <= tx_dv_d;
`endif
        end
    end

    // Payload buffer carries no reset; every frame rewrites the words it reads back
    always_ff @(posedge clk_ref) begin
        if (mem_we_c) begin
            mem_q[PW'(wr_cnt_q)] <= rx_q_i;
        end
    end

    assign pkt_data_o  = pkt_data_q;
    assign pkt_valid_o = pkt_valid_q;
    assign pkt_last_o  = pkt_last_q;
    assign frame_ok_o  = frame_ok_q;
    assign frame_err_o = frame_err_q;
    assign drop_o      = drop_q;

`ifdef DEFRAMER_ACK_EN
    assign tx_data_o = tx_data_q;
    assign tx_dv_o   = tx_dv_q;
`else
    assign tx_data_o = 16'h0000;
    assign tx_dv_o   = 1'b0;
    wire unused_tx_busy = tx_busy_i;
`endif

endmodule

// File: tb/tb_rs232_frame_deframer.sv
// Self-checking bench for rs232_frame_deframer: directed scenarios plus random frames against a frame-level model.
module tb_rs232_frame_deframer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 100;
`ifdef DEFRAMER_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic        clk_ref;
    logic        rst_n;
    logic [15:0] rx_q_i;
    logic        rx_dv_i;
    logic [15:0] tx_data_o;
    logic        tx_dv_o;
    logic        tx_busy_i;
    logic [15:0] pkt_data_o;
    logic        pkt_valid_o;
    logic        pkt_last_o;
    logic        pkt_ready_i;
    logic        frame_ok_o;
    logic        frame_err_o;
    logic        drop_o;

    rs232_frame_deframer #(
        .SYNC_BYTE  (8'h37),
        .DEPTH      (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_ref    (clk_ref),
        .rst_n      (rst_n),
        .rx_q_i     (rx_q_i),
        .rx_dv_i    (rx_dv_i),
        .tx_data_o  (tx_data_o),
        .tx_dv_o    (tx_dv_o),
        .tx_busy_i  (tx_busy_i),
        .pkt_data_o (pkt_data_o),
        .pkt_valid_o(pkt_valid_o),
        .pkt_last_o (pkt_last_o),
        .pkt_ready_i(pkt_ready_i),
        .frame_ok_o (frame_ok_o),
        .frame_err_o(frame_err_o),
        .drop_o     (drop_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int          ok_cnt    = 0;
    int          err_cnt   = 0;
    int          drop_cnt  = 0;
    int          stab_viol = 0;
    logic [16:0] got_pkt[$];
    logic [15:0] tx_q[$];
    logic        hold_prev = 1'b0;
    logic [16:0] prev_pd   = '0;

    int          b_ok, b_err, b_drop, b_pkt, b_tx, b_stab;
    int          exp_ok, exp_err, exp_drop;
    logic [16:0] exp_pkt[$];
    logic [15:0] exp_tx[$];
    logic [15:0] fw[$];
    int          rdy_mode = 0;

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    // Downstream ready: 0 always ready, 1 stalled, 2 random
    initial begin
        pkt_ready_i = 1'b0;
        forever begin
            @(posedge clk_ref);
            #1;
            case (rdy_mode)
                0:       pkt_ready_i = 1'b1;
                1:       pkt_ready_i = 1'b0;
                default: pkt_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk_ref) begin
        if (rst_n) begin
            if (pkt_valid_o && pkt_ready_i) got_pkt.push_back({pkt_last_o, pkt_data_o});
            if (tx_dv_o) tx_q.push_back(tx_data_o);
            if (frame_ok_o) ok_cnt++;
            if (frame_err_o) err_cnt++;
            if (drop_o) drop_cnt++;
            if (hold_prev && (!pkt_valid_o || ({pkt_last_o, pkt_data_o} != prev_pd))) stab_viol++;
            hold_prev = pkt_valid_o && !pkt_ready_i;
            prev_pd   = {pkt_last_o, pkt_data_o};
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, 64'({tx_data_o, tx_dv_o, pkt_data_o, pkt_valid_o, pkt_last_o,
                      frame_ok_o, frame_err_o, drop_o}), 64'd0);
    endtask

    // Frame-level reference: header rule, 16-bit modular sum, expected packet and ack
    task automatic model();
        logic [15:0] hdr;
        int unsigned n;
        int unsigned sum;
        exp_pkt.delete();
        exp_tx.delete();
        exp_ok   = 0;
        exp_err  = 0;
        exp_drop = 0;
        hdr = fw[0];
        if (hdr[15:8] != 8'h37) return;
        n = 32'(hdr[3:0]);
        if (n == 0 || n > DEPTH) begin
            exp_err = 1;
            return;
        end
        sum = 0;
        for (int unsigned i = 1; i <= n; i++) sum = (sum + 32'(fw[i])) % 65536;
        if (fw[n + 1] == 16'(sum)) begin
            exp_ok = 1;
            if (ACK_EN) exp_tx.push_back(16'hA5A5);
            for (int unsigned i = 1; i <= n; i++) exp_pkt.push_back({(i == n), fw[i]});
        end else begin
            exp_err = 1;
            if (ACK_EN) exp_tx.push_back(16'h5A5A);
        end
    endtask

    task automatic snap();
        b_ok   = ok_cnt;
        b_err  = err_cnt;
        b_drop = drop_cnt;
        b_pkt  = got_pkt.size();
        b_tx   = tx_q.size();
        b_stab = stab_viol;
    endtask

    task automatic send_word(input logic [15:0] w);
        @(posedge clk_ref);
        #1;
        rx_q_i  = w;
        rx_dv_i = 1'b1;
        @(posedge clk_ref);
        #1;
        rx_dv_i = 1'b0;
        rx_q_i  = 16'h0000;
    endtask

    task automatic send_words(input int gap_max);
        foreach (fw[i]) begin
            send_word(fw[i]);
            repeat ($urandom_range(0, gap_max)) @(posedge clk_ref);
        end
    endtask

    task automatic finish_frame(input string tag);
        int np;
        int nt;
        for (int c = 0; c < 400; c++) begin
            if ((ok_cnt - b_ok) >= exp_ok && (err_cnt - b_err) >= exp_err &&
                (got_pkt.size() - b_pkt) >= exp_pkt.size() &&
                (tx_q.size() - b_tx) >= exp_tx.size()) break;
            @(posedge clk_ref);
        end
        repeat (4) @(posedge clk_ref);
        #1;
        np = got_pkt.size() - b_pkt;
        nt = tx_q.size() - b_tx;
        chk({tag, "_ok"},   64'(ok_cnt - b_ok),       64'(exp_ok));
        chk({tag, "_err"},  64'(err_cnt - b_err),     64'(exp_err));
        chk({tag, "_drop"}, 64'(drop_cnt - b_drop),   64'(exp_drop));
        chk({tag, "_stab"}, 64'(stab_viol - b_stab),  64'd0);
        chk({tag, "_npkt"}, 64'(np),                  64'(exp_pkt.size()));
        for (int i = 0; i < np && i < exp_pkt.size(); i++)
            chk($sformatf("%s_pkt%0d", tag, i), 64'(got_pkt[b_pkt + i]), 64'(exp_pkt[i]));
        chk({tag, "_ntx"}, 64'(nt), 64'(exp_tx.size()));
        for (int i = 0; i < nt && i < exp_tx.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), 64'(tx_q[b_tx + i]), 64'(exp_tx[i]));
    endtask

    task automatic run_frame(input string tag, input int gap_max);
        model();
        snap();
        send_words(gap_max);
        finish_frame(tag);
    endtask

    initial begin
        int unsigned n;
        int unsigned sum;
        logic [7:0]  b;
        rst_n     = 1'b0;
        rx_q_i    = 16'h0000;
        rx_dv_i   = 1'b0;
        tx_busy_i = 1'b0;
        rdy_mode  = 0;
        repeat (3) @(posedge clk_ref);
        #1;
        chk_outs_zero("reset_outs");
        rst_n = 1'b1;

        fw = '{16'h3702, 16'h1234, 16'h0001, 16'h1235};
        run_frame("good", 1);
        fw = '{16'h3702, 16'hFFFF, 16'h0002, 16'h0001};
        run_frame("wrap", 2);
        fw = '{16'h3702, 16'h0001, 16'h0002, 16'h0004};
        run_frame("bad_trl", 0);
        fw = '{16'h3700};
        run_frame("len0", 0);
        fw = '{16'h3709};
        run_frame("len9", 0);
        fw = '{16'h4441};
        run_frame("nosync", 0);

        // Transmitter busy across the ack point
        tx_busy_i = 1'b1;
        fw = '{16'h3702, 16'h1234, 16'h0001, 16'h1235};
        model();
        snap();
        send_words(0);
        repeat (50) @(posedge clk_ref);
        #1;
        chk("busy_ntx",  64'(tx_q.size() - b_tx),    64'd0);
        chk("busy_npkt", 64'(got_pkt.size() - b_pkt), ACK_EN ? 64'd0 : 64'd2);
        tx_busy_i = 1'b0;
        finish_frame("busy");

        // Downstream stall in DRAIN with a stray word arriving
        rdy_mode = 1;
        fw = '{16'h3703, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h3331};
        model();
        exp_drop = 1;
        snap();
        send_words(0);
        for (int c = 0; c < 100 && !pkt_valid_o; c++) @(negedge clk_ref);
        repeat (2) @(posedge clk_ref);
        send_word(16'h3702);
        repeat (6) @(posedge clk_ref);
        #1;
        chk("stall_valid", 64'(pkt_valid_o), 64'd1);
        chk("stall_data",  64'({pkt_last_o, pkt_data_o}), 64'({1'b0, 16'hAAAA}));
        rdy_mode = 0;
        finish_frame("stall");

        // Inter-word timeout
        snap();
        exp_pkt.delete();
        exp_tx.delete();
        exp_ok = 0; exp_err = 1; exp_drop = 0;
        send_word(16'h3703);
        send_word(16'h0001);
        repeat (100) @(posedge clk_ref);
        finish_frame("timeout");
        fw = '{16'h3702, 16'h1234, 16'h0001, 16'h1235};
        run_frame("after_tmo", 1);

        // Sync word landing exactly on the timeout cycle opens a fresh frame
        snap();
        exp_pkt.delete();
        exp_tx.delete();
        exp_ok = 1; exp_err = 1; exp_drop = 0;
        exp_pkt.push_back({1'b1, 16'h0005});
        if (ACK_EN) exp_tx.push_back(16'hA5A5);
        send_word(16'h3702);
        send_word(16'h0001);
        repeat (98) @(posedge clk_ref);
        send_word(16'h3701);
        send_word(16'h0005);
        send_word(16'h0005);
        finish_frame("tmo_edge");

        // Reset mid-PAYLOAD
        send_word(16'h3704);
        send_word(16'h1111);
        rst_n = 1'b0;
        #1;
        chk_outs_zero("rst_payload_outs");
        repeat (2) @(posedge clk_ref);
        #1;
        rst_n = 1'b1;
        fw = '{16'h3702, 16'h1234, 16'h0001, 16'h1235};
        run_frame("post_rst_pl", 1);

        // Reset mid-DRAIN
        rdy_mode = 1;
        send_words(0);
        for (int c = 0; c < 100 && !pkt_valid_o; c++) @(negedge clk_ref);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs_zero("rst_drain_outs");
        repeat (3) @(posedge clk_ref);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        run_frame("post_rst_dr", 1);

        // Random frames, junk words and bad headers with random downstream back-pressure
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 9);
            fw.delete();
            if (r < 7) begin
                n = $urandom_range(1, DEPTH);
                fw.push_back({8'h37, 4'($urandom), 4'(n)});
                sum = 0;
                for (int unsigned i = 0; i < n; i++) begin
                    fw.push_back(16'($urandom));
                    sum = (sum + 32'(fw[i + 1])) % 65536;
                end
                if ($urandom_range(0, 1) == 0) fw.push_back(16'(sum));
                else fw.push_back(16'(sum) ^ 16'($urandom_range(1, 65535)));
            end else if (r < 8) begin
                b = 8'($urandom);
                while (b == 8'h37) b = 8'($urandom);
                fw.push_back({b, 8'($urandom)});
            end else begin
                n = $urandom_range(0, 7);
                if (n != 0) n = n + 8;
                fw.push_back({8'h37, 4'($urandom), 4'(n)});
            end
            run_frame($sformatf("rnd%0d", k), 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
